// File: rtl/jkr_cport_dpkt_mem_param_pkg.sv
// Shared widths and enums for the cport packet memory and its ingress write arbiter.
package jkr_cport_dpkt_mem_param_pkg;

  localparam int INGRESS_ADDR_WIDTH = 14;
  localparam int INGRESS_DATA_WIDTH = 512;

  typedef enum logic [1:0] {
    DPKT_WR_IDLE = 2'd0,
    DPKT_WR_BUSY = 2'd1,
    DPKT_WR_ACK  = 2'd2
  } dpkt_wr_arb_state_e;

endpackage

// File: rtl/jkr_rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping modulo N.
module jkr_rr_pick #(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_vld
);

  logic [ID_W:0] idx;

  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (ID_W + 1)'(i);
      if (idx >= (ID_W + 1)'(N)) begin
        idx = idx - (ID_W + 1)'(N);
      end
      if (!gnt_vld && req[idx[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/jkr_cport_dpkt_wr_arb.sv
// Round-robin ingress write arbiter for the packet memory: one write in flight,
// payload and parity forwarded untouched, per-requester ack and ack-timeout flag.
module jkr_cport_dpkt_wr_arb
  import jkr_cport_dpkt_mem_param_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = INGRESS_ADDR_WIDTH,
  parameter int DATA_W      = INGRESS_DATA_WIDTH,
  parameter int ACK_TIMEOUT = 64,
  localparam int PAR_W = DATA_W / 32,
  localparam int ID_W  = $clog2(NUM_REQ),
  localparam int TMO_W = $clog2(ACK_TIMEOUT)
) (
  input  logic                      i_core_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ*PAR_W-1:0]  i_req_data_parity,
  input  logic [NUM_REQ-1:0]        i_req_addr_parity,
  output logic [NUM_REQ-1:0]        o_req_ack,
  output logic                      o_wr_valid,
  output logic [ADDR_W-1:0]         o_core_addr,
  output logic [DATA_W-1:0]         o_data,
  output logic [PAR_W-1:0]          o_data_parity,
  output logic                      o_addr_parity,
  input  logic                      i_wr_ack,
  input  logic                      i_arb_en,
  output logic                      o_timeout_err,
  output logic [ID_W-1:0]           o_timeout_id,
  output logic                      o_busy
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  dpkt_wr_arb_state_e state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               tmo_hit;

  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic               wr_valid_q, wr_valid_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic [ID_W-1:0]    timeout_id_q, timeout_id_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [PAR_W-1:0]   dpar_q, dpar_d;
  logic               apar_q, apar_d;

  logic [ID_W-1:0]    pick_id;
  logic               pick_vld;

  jkr_rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (i_req_valid),
    .ptr     (rr_ptr_q),
    .gnt_id  (pick_id),
    .gnt_vld (pick_vld)
  );

  always_ff @(posedge i_core_clk) begin
    if (i_reset) begin
      state_q       <= DPKT_WR_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      tmo_cnt_q     <= '0;
      req_ack_q     <= '0;
      wr_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      dpar_q        <= '0;
      apar_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      tmo_cnt_q     <= tmo_cnt_d;
      req_ack_q     <= req_ack_d;
      wr_valid_q    <= wr_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      dpar_q        <= dpar_d;
      apar_q        <= apar_d;
    end
  end

  // An ack landing on the terminal count wins, so tmo_hit requires !i_wr_ack.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_hit    = 1'b0;
    case (state_q)
      DPKT_WR_IDLE: begin
        if (i_arb_en && pick_vld) begin
          state_d    = DPKT_WR_BUSY;
          grant_id_d = pick_id;
          tmo_cnt_d  = '0;
        end
      end
      DPKT_WR_BUSY: begin
        if (i_wr_ack) begin
          state_d = DPKT_WR_ACK;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = DPKT_WR_ACK;
          tmo_hit = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      DPKT_WR_ACK: begin
        rr_ptr_d = (grant_id_q == ID_LAST) ? '0 : grant_id_q + 1'b1;
        state_d  = DPKT_WR_IDLE;
      end
      default: state_d = DPKT_WR_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    wr_valid_d    = (state_d == DPKT_WR_BUSY);
    busy_d        = (state_d != DPKT_WR_IDLE);
    req_ack_d     = '0;
    timeout_err_d = 1'b0;
    timeout_id_d  = timeout_id_q;
    addr_d        = addr_q;
    data_d        = data_q;
    dpar_d        = dpar_q;
    apar_d        = apar_q;
    if (state_q == DPKT_WR_IDLE && state_d == DPKT_WR_BUSY) begin
      addr_d = i_req_addr[pick_id*ADDR_W +: ADDR_W];
      data_d = i_req_data[pick_id*DATA_W +: DATA_W];
      dpar_d = i_req_data_parity[pick_id*PAR_W +: PAR_W];
      apar_d = i_req_addr_parity[pick_id];
    end
    if (state_d == DPKT_WR_ACK) begin
      req_ack_d[grant_id_q] = 1'b1;
      if (tmo_hit) begin
        timeout_err_d = 1'b1;
        timeout_id_d  = grant_id_q;
      end
    end
  end

  assign o_req_ack     = req_ack_q;
  assign o_wr_valid    = wr_valid_q;
  assign o_busy        = busy_q;
  assign o_timeout_err = timeout_err_q;
  assign o_timeout_id  = timeout_id_q;
  assign o_core_addr   = addr_q;
  assign o_data        = data_q;
  assign o_data_parity = dpar_q;
  assign o_addr_parity = apar_q;

endmodule

// File: doc/jkr_cport_dpkt_wr_arb.md
# jkr_cport_dpkt_wr_arb

Round-robin write arbiter and sequencer for the ingress port of `jkr_cport_dpkt_mem_top`. It sits in the core clock domain between `NUM_REQ` ingress requesters and the single `i_wr_valid`/`o_wr_ack` write port of the packet memory. It registers and forwards one write at a time with its address and data parity unmodified. It returns a per-requester ack and flags writes the memory never acknowledges.

## Interface
- `NUM_REQ`, 4: number of ingress requesters (2..8).
- `ADDR_W`, `INGRESS_ADDR_WIDTH`: core address width.
- `DATA_W`, `INGRESS_DATA_WIDTH` (512): data width; parity width is `DATA_W/32`.
- `ACK_TIMEOUT`, 64: maximum cycles in BUSY without `i_wr_ack` (≥2).

Ports:
- `i_core_clk`  in  1  the only clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  NUM_REQ  per-requester write request.
- `i_req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester r at slice r.
- `i_req_data`  in  NUM_REQ*DATA_W  packed data.
- `i_req_data_parity`  in  NUM_REQ*DATA_W/32  packed per-32b-chunk parity.
- `i_req_addr_parity`  in  NUM_REQ  address parity.
- `o_req_ack`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `o_wr_valid`  out  1  to memory `i_wr_valid`.
- `o_core_addr`  out  ADDR_W  to memory `i_core_addr`.
- `o_data`  out  DATA_W  to memory `i_data`.
- `o_data_parity`  out  DATA_W/32  to memory `i_data_parity`.
- `o_addr_parity`  out  1  to memory `i_addr_parity`.
- `i_wr_ack`  in  1  from memory `o_wr_ack`.
- `i_arb_en`  in  1  CSR enable for new grants.
- `o_timeout_err`  out  1  one-cycle pulse on ack timeout.
- `o_timeout_id`  out  $clog2(NUM_REQ)  requester that timed out; held until next timeout.
- `o_busy`  out  1  high when the state is not IDLE.

## Operation
- FSM has three states: IDLE, BUSY and ACK.
- IDLE: if `i_arb_en` and `|i_req_valid`, pick the first valid requester at or above `rr_ptr`, wrapping modulo NUM_REQ. Latch its addr, data and both parities into the output registers. Latch `grant_id`, clear `tmo_cnt`, and go to BUSY.
- BUSY: `o_wr_valid`=1 and the payload is held stable.
  - If `i_wr_ack`=1, go to ACK.
  - Otherwise, if `tmo_cnt == ACK_TIMEOUT-1`, go to ACK with a timeout flag set.
  - Otherwise increment `tmo_cnt`.
- ACK: `o_wr_valid`=0 and `o_req_ack[grant_id]`=1 for one cycle.
  - On timeout, `o_timeout_err`=1 in the same cycle and `o_timeout_id`=`grant_id`.
  - `rr_ptr <= (grant_id+1) mod NUM_REQ`, then go to IDLE.
  - No arbitration happens in ACK. This gives the requester one cycle to drop `valid` or present its next payload.
- Requester rules: a requester holds `valid` and its payload stable until it sees its `o_req_ack`. Deasserting `valid` before the ack is illegal; the in-flight write completes regardless.
- `i_wr_ack` is ignored outside BUSY, including late acks after a timeout.
- `i_arb_en`=0 blocks only the IDLE→BUSY transition; an in-flight write completes.
- Parity is never computed or checked here. It passes bit-exact so the memory's checkers see source errors.

## Timing
- Reset: state IDLE, `rr_ptr`=0, `tmo_cnt`=0. `o_wr_valid`, `o_req_ack`, `o_timeout_err`, `o_busy`, `o_timeout_id` and all payload outputs are 0.
- Reset mid-operation drops `o_wr_valid` on the next edge and produces no ack.
- Grant latency: valid sampled in IDLE at cycle 0 gives `o_wr_valid`=1 from cycle 1.
- `i_wr_ack` is accepted in any BUSY cycle, including the first one (cycle 1).
- Ack sampled at cycle k gives `o_req_ack` at k+1, IDLE at k+2, and the next `o_wr_valid` at k+3 at the earliest.
- Minimum period is 3 cycles per write.
- Timeout: with no ack, `o_wr_valid` is high for exactly ACK_TIMEOUT cycles, then ACK with `o_timeout_err`.
- If `i_wr_ack` and the timeout terminal count land in the same cycle, the ack wins and no error is raised.
- All outputs are registered.

## Structure
- Add `dpkt_wr_arb_state_e` (IDLE/BUSY/ACK) to `jkr_cport_dpkt_mem_param_pkg`, next to the existing `INGRESS_*` widths.
- The `tmo_cnt` width is `$clog2(ACK_TIMEOUT)`.
- The round-robin picker is the one natural sub-module: `jkr_rr_pick`, combinational, taking `req` and `ptr` and producing `gnt_id` and `gnt_vld`. It is reusable for the RISC read side.

## Test plan
- Single requester: `i_req_valid`=4'b0010 with addr 0x1A3, good parity, ack at the first BUSY cycle. Expect `o_wr_valid` for exactly 1 cycle with `o_core_addr`=0x1A3 and `o_req_ack`=4'b0010 one cycle later.
- All four requesters valid continuously, ack after 2 cycles each. Expect grant order 0,1,2,3,0 and writes 5 cycles apart.
- Requester 2 holds a bad-data-parity payload. Expect `o_data_parity` to equal the input bit-exact, and the memory's `o_we_err_info_data_out` to fire.
- No ack with ACK_TIMEOUT=8 on requester 3. Expect `o_wr_valid` high 8 cycles, then `o_timeout_err`=1 and `o_timeout_id`=3 with `o_req_ack`=4'b1000. A late ack afterwards is ignored.
- `i_arb_en`=0 while in BUSY. Expect that write to complete and no new `o_wr_valid` until `i_arb_en`=1.
- `i_reset` pulsed in BUSY. Expect all outputs 0 next cycle, no `o_req_ack`, and the next grant to go to requester 0.
